pulse_sync_scheduler: RTL and testbench

//   Shares one slow-to-fast pulse synchronizer channel (pulse_syn) between N_REQ requesters in the source domain.

---
 rtl/pulse_sync_scheduler_pkg.sv | 19 +
 rtl/pulse_sync_scheduler_rr_arbiter.sv | 31 +++
 rtl/pulse_sync_scheduler.sv | 115 +++++++++++
 tb/tb_pulse_sync_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sync_scheduler_pkg.sv
// Shared types for the pulse synchronizer scheduler: FSM state encoding and
// sizing of the shared wait/gap counter.
package pulse_sync_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } state_e;

    // One counter serves both the ack timeout and the recovery gap.
    function automatic int cnt_width(input int gap_cyc, input int tmo_cyc);
        int m;
        m = (gap_cyc > tmo_cyc) ? gap_cyc : tmo_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulse_sync_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping at N_REQ-1 back to 0 (non-power-of-2 N_REQ supported).
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             any_req
);

    logic [ID_W:0] idx;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        grant   = '0;
        any_req = |req;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(N_REQ)) begin
                idx = idx - (ID_W + 1)'(N_REQ);
            end
            if (req[idx[ID_W-1:0]]) begin
                grant = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pulse_sync_scheduler.sv
// Source-domain scheduler sharing one pulse synchronizer between N_REQ
// requesters: latch, round-robin grant, issue, await ack, enforce gap.
module pulse_sync_scheduler
    import pulse_sync_scheduler_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int GAP_CYC = 6,
    parameter int TMO_CYC = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             sync_ack,
    input  logic             err_clr,
    output logic             sync_pulse,
    output logic [ID_W-1:0]  sync_id,
    output logic [N_REQ-1:0] pending,
    output logic             busy,
    output logic [N_REQ-1:0] overflow,
    output logic             err_tmo
);

    localparam int CNT_W = cnt_width(GAP_CYC, TMO_CYC);

    state_e           state, state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_nxt;
    logic [ID_W-1:0]  grant;
    logic             any_req;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N_REQ-1:0] clr_mask;
    logic             tmo_evt;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (pending),
        .ptr     (rr_ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_mask  = '0;
        tmo_evt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt       = ST_ISSUE;
                    clr_mask[grant] = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT_ACK;
                cnt_nxt   = '0;
            end
            ST_WAIT_ACK: begin
                if (sync_ack) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(TMO_CYC - 1)) begin
                    tmo_evt   = 1'b1;
                    state_nxt = ST_GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == CNT_W'(GAP_CYC - 1)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // sync_id still holds the current grant while in ISSUE.
    assign rr_nxt = (sync_id == ID_W'(N_REQ - 1)) ? '0 : sync_id + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rr_ptr   <= '0;
            sync_id  <= '0;
            pending  <= '0;
            overflow <= '0;
            err_tmo  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == ST_IDLE && any_req) begin
                sync_id <= grant;
            end
            if (state == ST_ISSUE) begin
                rr_ptr <= rr_nxt;
            end
            // A new request on the bit being granted re-arms it rather than overflowing.
            pending  <= (pending & ~clr_mask) | req_pulse;
            overflow <= (err_clr ? '0 : overflow) | (req_pulse & pending & ~clr_mask);
            err_tmo  <= (err_clr ? 1'b0 : err_tmo) | tmo_evt;
        end
    end

    assign sync_pulse = (state == ST_ISSUE);
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_pulse_sync_scheduler.sv
// Randomized and directed bench for pulse_sync_scheduler against a
// timestamp-based transfer model.
module tb_pulse_sync_scheduler;

    localparam int N   = 4;
    localparam int GAP = 6;
    localparam int TMO = 31;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_pulse;
    logic        sync_ack;
    logic        err_clr;
    logic        sync_pulse;
    logic [1:0]  sync_id;
    logic [3:0]  pending;
    logic        busy;
    logic [3:0]  overflow;
    logic        err_tmo;
    logic [12:0] act_vec;

    int checks   = 0;
    int failures = 0;

    pulse_sync_scheduler #(
        .N_REQ   (N),
        .ID_W    (2),
        .GAP_CYC (GAP),
        .TMO_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_pulse  (req_pulse),
        .sync_ack   (sync_ack),
        .err_clr    (err_clr),
        .sync_pulse (sync_pulse),
        .sync_id    (sync_id),
        .pending    (pending),
        .busy       (busy),
        .overflow   (overflow),
        .err_tmo    (err_tmo)
    );

    always #5 clk = ~clk;

    assign act_vec = {sync_pulse, sync_id, pending, busy, overflow, err_tmo};

    // Model: a transfer is described by its issue cycle and the cycle its wait ended.
    int       cyc   = 0;
    bit       m_x   = 0;
    int       m_ti  = -1;
    int       m_te  = -1;
    bit       m_ted = 0;
    int       m_rr  = 0;
    int       m_id  = 0;
    bit [3:0] m_pend = '0;
    bit [3:0] m_ovf  = '0;
    bit       m_tmo  = 0;

    function void model_step(input bit [3:0] r, input bit a, input bit c, input bit rn);
        bit [3:0] clr_m;
        bit       tmo_evt;
        bit       start;
        int       g;
        clr_m = '0; tmo_evt = 0; start = 0; g = 0;
        if (!rn) begin
            m_x = 0; m_ted = 0; m_rr = 0; m_id = 0;
            m_pend = '0; m_ovf = '0; m_tmo = 0;
        end else begin
            if (!m_x && m_pend != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (!start && m_pend[(m_rr + k) % N]) begin
                        start = 1;
                        g = (m_rr + k) % N;
                    end
                end
                clr_m[g] = 1'b1;
            end
            if (m_x) begin
                if (!m_ted && cyc > m_ti) begin
                    if (a) begin
                        m_ted = 1; m_te = cyc;
                    end else if (cyc - m_ti == TMO) begin
                        tmo_evt = 1; m_ted = 1; m_te = cyc;
                    end
                end else if (m_ted && cyc == m_te + GAP) begin
                    m_x = 0;
                end
            end
            if (start) begin
                m_x = 1; m_ti = cyc + 1; m_ted = 0; m_id = g; m_rr = (g + 1) % N;
            end
            m_ovf  = (c ? 4'b0 : m_ovf) | (r & m_pend & ~clr_m);
            m_tmo  = (c ? 1'b0 : m_tmo) | tmo_evt;
            m_pend = (m_pend & ~clr_m) | r;
        end
        cyc++;
    endfunction

    function logic [12:0] exp_vec();
        return {(m_x && cyc == m_ti), 2'(m_id), m_pend, m_x, m_ovf, m_tmo};
    endfunction

    task automatic tick(input logic [3:0] r, input logic a, input logic c, input logic rn);
        req_pulse = r; sync_ack = a; err_clr = c; rst_n = rn;
        @(posedge clk);
        model_step(r, a, c, rn);
        @(negedge clk);
        req_pulse = '0; sync_ack = 1'b0; err_clr = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick(4'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (act_vec !== 13'b0) begin
            failures++; $display("FAIL reset_outputs: dut=%b want=%b", act_vec, 13'b0);
        end
        tick(4'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (act_vec !== exp_vec()) begin
            failures++; $display("FAIL reset_idle_ack: dut=%b model=%b", act_vec, exp_vec());
        end
    endtask

    task automatic test_single();
        int busy_cnt;
        int since;
        tick(4'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0001, 1'b0, 1'b0, 1'b1);
        checks++;
        if (pending !== 4'b0001 || sync_pulse !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL single_latch: pend=%b pulse=%b busy=%b want 0001/0/0", pending, sync_pulse, busy);
        end
        tick(4'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (sync_pulse !== 1'b1 || sync_id !== 2'd0 || pending !== 4'b0) begin
            failures++; $display("FAIL single_issue: pulse=%b id=%0d pend=%b want 1/0/0000", sync_pulse, sync_id, pending);
        end
        busy_cnt = 1;
        since = 0;
        for (int i = 0; i < 40; i++) begin
            tick(4'b0, since == 4, 1'b0, 1'b1);
            since++;
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++; $display("FAIL single_cyc%0d: dut=%b model=%b", since, act_vec, exp_vec());
            end
            if (busy) busy_cnt++;
            else break;
        end
        checks++;
        if (busy_cnt != 11) begin
            failures++; $display("FAIL single_busy_len: got=%0d want=11", busy_cnt);
        end
    endtask

    task automatic test_all_four();
        int n_pulse;
        int last;
        int ids[$];
        tick(4'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b1111, 1'b0, 1'b0, 1'b1);
        n_pulse = 0;
        last = -100;
        for (int i = 0; i < 60; i++) begin
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++; $display("FAIL all4_cyc%0d: dut=%b model=%b", i, act_vec, exp_vec());
            end
            if (sync_pulse) begin
                if (n_pulse > 0) begin
                    checks++;
                    if (i - last < 9) begin
                        failures++; $display("FAIL all4_spacing: got=%0d want>=9", i - last);
                    end
                end
                ids.push_back(int'(sync_id));
                n_pulse++;
                last = i;
            end
            tick(4'b0, 1'b1, 1'b0, 1'b1);
        end
        checks++;
        if (n_pulse != 4) begin
            failures++; $display("FAIL all4_count: got=%0d want=4", n_pulse);
        end
        for (int i = 0; i < ids.size() && i < 4; i++) begin
            checks++;
            if (ids[i] != i) begin
                failures++; $display("FAIL all4_id%0d: got=%0d want=%0d", i, ids[i], i);
            end
        end
    endtask

    task automatic test_wrap();
        int ids[$];
        int want[3] = '{1, 3, 1};
        tick(4'b0010, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 80; i++) begin
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++; $display("FAIL wrap_cyc%0d: dut=%b model=%b", i, act_vec, exp_vec());
            end
            if (sync_pulse) ids.push_back(int'(sync_id));
            tick((i == 3) ? 4'b1010 : 4'b0, 1'b1, 1'b0, 1'b1);
        end
        checks++;
        if (ids.size() != 3) begin
            failures++; $display("FAIL wrap_count: got=%0d want=3", ids.size());
        end
        for (int i = 0; i < ids.size() && i < 3; i++) begin
            checks++;
            if (ids[i] != want[i]) begin
                failures++; $display("FAIL wrap_id%0d: got=%0d want=%0d", i, ids[i], want[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int n2;
        tick(4'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0001, 1'b0, 1'b0, 1'b1);
        tick(4'b0100, 1'b0, 1'b0, 1'b1);
        tick(4'b0100, 1'b0, 1'b0, 1'b1);
        tick(4'b0100, 1'b0, 1'b0, 1'b1);
        checks++;
        if (overflow !== 4'b0100 || pending !== 4'b0100) begin
            failures++; $display("FAIL ovf_flag: ovf=%b pend=%b want 0100/0100", overflow, pending);
        end
        n2 = 0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++; $display("FAIL ovf_cyc%0d: dut=%b model=%b", i, act_vec, exp_vec());
            end
            if (sync_pulse && sync_id == 2'd2) n2++;
            tick(4'b0, 1'b1, 1'b0, 1'b1);
        end
        checks++;
        if (n2 != 1) begin
            failures++; $display("FAIL ovf_single_pulse: got=%0d want=1", n2);
        end
        tick(4'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (overflow !== 4'b0) begin
            failures++; $display("FAIL ovf_clear: got=%b want=0000", overflow);
        end
    endtask

    task automatic test_timeout();
        int t_err;
        int t_next;
        tick(4'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0001, 1'b0, 1'b0, 1'b1);
        tick(4'b0010, 1'b0, 1'b0, 1'b1);
        t_err = -1;
        t_next = -1;
        for (int since = 1; since <= 45; since++) begin
            tick(4'b0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++; $display("FAIL tmo_cyc%0d: dut=%b model=%b", since, act_vec, exp_vec());
            end
            if (err_tmo && t_err < 0) t_err = since;
            if (sync_pulse && t_next < 0) begin
                t_next = since;
                checks++;
                if (sync_id !== 2'd1) begin
                    failures++; $display("FAIL tmo_next_id: got=%0d want=1", sync_id);
                end
            end
        end
        checks++;
        if (t_err != 32) begin
            failures++; $display("FAIL tmo_when: got=%0d want=32", t_err);
        end
        checks++;
        if (t_next != 39) begin
            failures++; $display("FAIL tmo_next_issue: got=%0d want=39", t_next);
        end
        tick(4'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (err_tmo !== 1'b0) begin
            failures++; $display("FAIL tmo_clear: got=%b want=0", err_tmo);
        end
    endtask

    task automatic test_reset_mid();
        tick(4'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0001, 1'b0, 1'b0, 1'b1);
        tick(4'b0, 1'b0, 1'b0, 1'b1);
        tick(4'b0, 1'b0, 1'b0, 1'b1);
        tick(4'b0, 1'b0, 1'b0, 1'b1);
        tick(4'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (act_vec !== 13'b0) begin
            failures++; $display("FAIL rstmid_outputs: dut=%b want=%b", act_vec, 13'b0);
        end
        for (int i = 0; i < 12; i++) begin
            tick(4'b0, i == 0, 1'b0, 1'b1);
            checks++;
            if (sync_pulse !== 1'b0 || busy !== 1'b0 || pending !== 4'b0 || err_tmo !== 1'b0) begin
                failures++; $display("FAIL rstmid_quiet%0d: pulse=%b busy=%b pend=%b tmo=%b want all 0", i, sync_pulse, busy, pending, err_tmo);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic a, c, rn;
        tick(4'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            a  = ($urandom_range(0, 9) == 0);
            c  = ($urandom_range(0, 49) == 0);
            rn = ($urandom_range(0, 399) != 0);
            tick(r, a, c, rn);
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++; $display("FAIL rand_cyc%0d: dut=%b model=%b", i, act_vec, exp_vec());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_pulse = '0; sync_ack = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
